// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg
// Shared types for the instruction-fetch stage: the FSM state enum, the NOP
// word and the instruction/address record that is used both for the IF/ID
// output and for the one-entry pending buffer.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        valid;
  } fetch_rec_t;

  // Bubble matches the IF/ID flush value: all-zero instruction and address.
  localparam fetch_rec_t BUBBLE = '{data: NOP, addr: 32'h0000_0000, valid: 1'b0};

  function automatic fetch_rec_t make_rec(input logic [31:0] data, input logic [31:0] addr);
    fetch_rec_t r;
    r.data  = data;
    r.addr  = addr;
    r.valid = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/if_fetch_perf.sv
// if_fetch_perf
// Counter bank for the fetch stage. Three free-running 32-bit counters that
// wrap at 2^32 and clear on reset. Only instantiated when IF_FETCH_PERF_EN
// is defined.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_inc_fetched     one accepted, non-dropped instruction this cycle
//   i_inc_stall       stall cycle (FULL, or FETCH without ack)
//   i_inc_discard     one dropped response this cycle
//   perf_fetched      count of accepted instructions
//   perf_stall        count of stall cycles
//   perf_discard      count of dropped responses
module if_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc_fetched,
  input  logic        i_inc_stall,
  input  logic        i_inc_discard,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_discard
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall;
  logic [31:0] r_discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetched <= 32'd0;
      r_stall   <= 32'd0;
      r_discard <= 32'd0;
    end else begin
      if (i_inc_fetched) r_fetched <= r_fetched + 32'd1;
      if (i_inc_stall)   r_stall   <= r_stall + 32'd1;
      if (i_inc_discard) r_discard <= r_discard + 32'd1;
    end
  end

  assign perf_fetched = r_fetched;
  assign perf_stall   = r_stall;
  assign perf_discard = r_discard;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, issues one outstanding request at a
// time to instruction memory over req/ack, buffers one word when IF/ID is
// holding, and kills wrong-path fetches on redirect. With nothing to present
// it drives a bubble (all-zero instruction/address, valid low).
//
// Optional feature macro: IF_FETCH_PERF_EN adds perf_fetched, perf_stall and
// perf_discard counter outputs (if_fetch_perf). Fetch behaviour is identical
// with or without it.
//
// Parameters:
//   RESET_PC      PC loaded on reset
//   PC_STEP       PC increment per fetched word
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   hold          IF/ID hold; presented instruction is not consumed
//   redirect      taken branch/jump, redirect_pc is the target
//   imem_req/addr fetch request; addr held stable until the ack edge
//   imem_ack      response valid, imem_rdata carries the word
//   instr, instr_add, instr_valid   record presented to IF/ID
//
// FSM:
//   IDLE    | one cycle after reset, no request
//   FETCH   | request outstanding at imem_addr = pc
//   FULL    | output and pending buffer both occupied, no request
//   DISCARD | wrong-path request still outstanding, its response is dropped
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_add,
  output logic        instr_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_discard
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_req;
  logic [31:0]  r_addr;
  fetch_rec_t   r_out;
  fetch_rec_t   r_pend;

  logic [31:0]  w_pc_next;

  assign w_pc_next = r_pc + PC_STEP;

  // imem_addr is its own register rather than a copy of pc: in DISCARD the
  // pc already holds the redirect target while the old request must stay
  // on the bus until memory acknowledges it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_out   <= BUBBLE;
      r_pend  <= BUBBLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end

        ST_FETCH: begin
          if (redirect) begin
            r_pc  <= redirect_pc;
            r_out <= BUBBLE;
            if (!imem_ack) begin
              // keep the wrong-path request on the bus until it completes
              r_state <= ST_DISCARD;
            end else begin
              r_addr <= redirect_pc;
            end
          end else if (imem_ack && (!r_out.valid || !hold)) begin
            r_out  <= make_rec(imem_rdata, r_pc);
            r_pc   <= w_pc_next;
            r_addr <= w_pc_next;
          end else if (imem_ack) begin
            r_pend  <= make_rec(imem_rdata, r_pc);
            r_pc    <= w_pc_next;
            r_addr  <= w_pc_next;
            r_req   <= 1'b0;
            r_state <= ST_FULL;
          end else if (!hold) begin
            r_out <= BUBBLE;
          end
        end

        ST_FULL: begin
          if (redirect) begin
            r_pc    <= redirect_pc;
            r_addr  <= redirect_pc;
            r_out   <= BUBBLE;
            r_pend  <= BUBBLE;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end else if (!hold) begin
            r_out   <= r_pend;
            r_pend  <= BUBBLE;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_state <= ST_FETCH;
          end
        end

        ST_DISCARD: begin
          r_out <= BUBBLE;
          if (redirect) begin
            r_pc <= redirect_pc;
            // An ack on the same edge still closes the old handshake, so the
            // next request can go straight to the new target.
            if (imem_ack) begin
              r_addr  <= redirect_pc;
              r_state <= ST_FETCH;
            end
          end else if (imem_ack) begin
            r_addr  <= r_pc;
            r_state <= ST_FETCH;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_out.data;
  assign instr_add   = r_out.addr;
  assign instr_valid = r_out.valid;

`ifdef IF_FETCH_PERF_EN
  logic w_inc_fetched;
  logic w_inc_stall;
  logic w_inc_discard;

  assign w_inc_fetched = (r_state == ST_FETCH) && imem_ack && !redirect;
  assign w_inc_stall   = (r_state == ST_FULL) || ((r_state == ST_FETCH) && !imem_ack);
  assign w_inc_discard = imem_ack &&
                         (((r_state == ST_FETCH) && redirect) || (r_state == ST_DISCARD));

  if_fetch_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_inc_fetched (w_inc_fetched),
    .i_inc_stall   (w_inc_stall),
    .i_inc_discard (w_inc_discard),
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
    .perf_discard  (perf_discard)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_add;
  logic        instr_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_discard;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RPC), .PC_STEP(32'd4)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_add   (instr_add),
    .instr_valid (instr_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
    .perf_discard (perf_discard)
`endif
  );

  // ---------------- reference model ----------------
  // Viewed as: a PC, a presented record, a FIFO of at most one waiting word,
  // and one memory request that may have been killed by a redirect.
  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
  } rec_t;

  bit          m_started;
  bit          m_killed;
  logic [31:0] m_kill_addr;
  logic [31:0] m_pc;
  logic [31:0] m_i;
  logic [31:0] m_a;
  logic        m_v;
  rec_t        m_wait[$];
  int unsigned m_fet, m_stall, m_disc;

  function automatic logic m_req();
    return m_started && (m_wait.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    if (!m_started) return RPC;
    if (m_killed) return m_kill_addr;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_started = 0; m_killed = 0; m_kill_addr = 0; m_pc = RPC;
    m_i = 0; m_a = 0; m_v = 0; m_wait.delete();
    m_fet = 0; m_stall = 0; m_disc = 0;
  endtask

  task automatic model_edge(input logic h, input logic r, input logic [31:0] rp,
                            input logic a, input logic [31:0] d);
    rec_t w;
    bit requesting;
    requesting = m_started && (m_wait.size() == 0);
    if (m_wait.size() != 0) m_stall++;
    if (requesting && !m_killed && !a) m_stall++;
    if (requesting && !m_killed && a && !r) m_fet++;
    if (requesting && a && (m_killed || r)) m_disc++;

    if (!m_started) begin
      m_started = 1;
    end else if (m_wait.size() != 0) begin
      if (r) begin
        m_pc = rp; m_i = 0; m_a = 0; m_v = 0; m_wait.delete();
      end else if (!h) begin
        m_i = m_wait[0].d; m_a = m_wait[0].a; m_v = 1; m_wait.delete();
      end
    end else if (r) begin
      if (a) m_killed = 0;
      else begin
        if (!m_killed) m_kill_addr = m_pc;
        m_killed = 1;
      end
      m_pc = rp; m_i = 0; m_a = 0; m_v = 0;
    end else if (m_killed) begin
      if (a) m_killed = 0;
    end else if (a) begin
      w.d = d; w.a = m_pc;
      m_pc = m_pc + 32'd4;
      if (m_v && h) m_wait.push_back(w);
      else begin m_i = w.d; m_a = w.a; m_v = 1; end
    end else if (!h) begin
      m_i = 0; m_a = 0; m_v = 0;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic cycle(input logic h, input logic r, input logic [31:0] rp,
                       input logic a, input logic [31:0] d);
    logic ak;
    ak = a & m_req();
    hold = h; redirect = r; redirect_pc = rp; imem_ack = ak;
    imem_rdata = ak ? d : 32'hDEAD_BEEF;
    @(posedge clk);
    model_edge(h, r, rp, ak, d);
    #1;
    redirect = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 0; redirect = 0; imem_ack = 0; redirect_pc = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; hold = 0; redirect = 0; imem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_req_valid got req=%b valid=%b exp 0 0", imem_req, instr_valid);
    end
    checks++;
    if ({instr, instr_add} !== 64'h0) begin
      errors++; $display("FAIL reset_out got instr=%h add=%h exp 0 0", instr, instr_add);
    end
    checks++;
    if (imem_addr !== RPC) begin
      errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RPC);
    end
    rst = 1'b0;
    model_reset();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL cycle1_req got %b exp 0", imem_req);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0000}) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp 1 00400000", imem_req, imem_addr);
    end
    cycle(0, 0, 0, 1, 32'h2008_0005);
    checks++;
    if ({instr, instr_add, instr_valid} !== {32'h2008_0005, 32'h0040_0000, 1'b1}) begin
      errors++; $display("FAIL first_out got %h @%h v=%b exp 20080005 @00400000 v=1", instr, instr_add, instr_valid);
    end
    checks++;
    if (imem_addr !== 32'h0040_0004) begin
      errors++; $display("FAIL first_next_addr got %h exp 00400004", imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 32'h1000_0000 + i);
      checks++;
      if ({instr_add, instr_valid, instr} !== {RPC + 32'(4 * i), 1'b1, 32'h1000_0000 + 32'(i)}) begin
        errors++; $display("FAIL stream_%0d got %h @%h v=%b exp @%h v=1", i, instr, instr_add, instr_valid, RPC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_hold_full();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hAAAA_0000);
    cycle(1, 0, 0, 1, 32'hAAAA_0004);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, instr_add, instr, instr_valid} !== {1'b0, RPC, 32'hAAAA_0000, 1'b1}) begin
        errors++; $display("FAIL full_frozen_%0d got req=%b %h @%h v=%b exp req=0 aaaa0000 @%h", i, imem_req, instr, instr_add, instr_valid, RPC);
      end
      cycle(1, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({instr_add, instr, instr_valid} !== {32'h0040_0004, 32'hAAAA_0004, 1'b1}) begin
      errors++; $display("FAIL full_release got %h @%h v=%b exp aaaa0004 @00400004", instr, instr_add, instr_valid);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0008}) begin
      errors++; $display("FAIL full_resume got req=%b addr=%h exp 1 00400008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_delayed();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0040_0100, 0, 0);
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, RPC}) begin
      errors++; $display("FAIL redir_kill got v=%b req=%b addr=%h exp 0 1 %h", instr_valid, imem_req, imem_addr, RPC);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (imem_addr !== RPC) begin
      errors++; $display("FAIL redir_hold_addr got %h exp %h", imem_addr, RPC);
    end
    cycle(0, 0, 0, 1, 32'h1234_5678);
    checks++;
    if ({instr_valid, instr, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h0040_0100}) begin
      errors++; $display("FAIL redir_drop got v=%b instr=%h req=%b addr=%h exp 0 0 1 00400100", instr_valid, instr, imem_req, imem_addr);
    end
`ifdef IF_FETCH_PERF_EN
    checks++;
    if (perf_discard !== 32'd1) begin
      errors++; $display("FAIL redir_perf_discard got %0d exp 1", perf_discard);
    end
`endif
  endtask

  task automatic test_redirect_ack_hold();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h5555_0000);
    cycle(1, 1, 32'h0040_0200, 1, 32'h5555_0004);
    checks++;
    if ({instr_valid, instr_add, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h0040_0200}) begin
      errors++; $display("FAIL redir_ack got v=%b add=%h req=%b addr=%h exp 0 0 1 00400200", instr_valid, instr_add, imem_req, imem_addr);
    end
    cycle(0, 0, 0, 1, 32'h6666_0000);
    checks++;
    if ({instr_add, instr, instr_valid} !== {32'h0040_0200, 32'h6666_0000, 1'b1}) begin
      errors++; $display("FAIL redir_ack_target got %h @%h v=%b exp 66660000 @00400200", instr, instr_add, instr_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFF8, 0, 0);
    cycle(0, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h7777_0001);
    cycle(0, 0, 0, 1, 32'h7777_0002);
    checks++;
    if ({instr_add, instr_valid, imem_addr} !== {32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap got add=%h v=%b next=%h exp fffffffc 1 00000000", instr_add, instr_valid, imem_addr);
    end
  endtask

  task automatic test_reset_in_full();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hBBBB_0000);
    cycle(1, 0, 0, 1, 32'hBBBB_0004);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, instr_valid, instr, instr_add, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, RPC}) begin
      errors++; $display("FAIL async_reset got req=%b v=%b %h @%h addr=%h", imem_req, instr_valid, instr, instr_add, imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hCCCC_0000);
    checks++;
    if ({instr_add, instr, instr_valid} !== {RPC, 32'hCCCC_0000, 1'b1}) begin
      errors++; $display("FAIL after_reset got %h @%h v=%b exp cccc0000 @%h", instr, instr_add, instr_valid, RPC);
    end
  endtask

  task automatic test_random();
    logic        h, r, a;
    logic [31:0] rp, d;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      h  = ($urandom_range(0, 99) < 40);
      r  = ($urandom_range(0, 99) < 8);
      a  = ($urandom_range(0, 99) < 65);
      rp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      d  = $urandom;
      cycle(h, r, rp, a, d);
      checks++;
      if ({instr, instr_add, instr_valid, imem_req, imem_addr} !== {m_i, m_a, m_v, m_req(), m_addr()}) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_%0d got %h @%h v=%b req=%b addr=%h exp %h @%h v=%b req=%b addr=%h",
                   n, instr, instr_add, instr_valid, imem_req, imem_addr, m_i, m_a, m_v, m_req(), m_addr());
      end
    end
`ifdef IF_FETCH_PERF_EN
    checks++;
    if ({perf_fetched, perf_stall, perf_discard} !== {32'(m_fet), 32'(m_stall), 32'(m_disc)}) begin
      errors++; $display("FAIL random_perf got %0d %0d %0d exp %0d %0d %0d", perf_fetched, perf_stall, perf_discard, m_fet, m_stall, m_disc);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_fetch();
    test_stream();
    test_hold_full();
    test_redirect_delayed();
    test_redirect_ack_hold();
    test_wrap();
    test_reset_in_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
